draw_sprite_line: RTL and testbench

Consumer of the per-line sprite buffer produced by the line-preparation stage. Once a line's sprite list is ready, it walks the buffer entries, re-reads each object's OAM word, fetches the matching 16-pixel sprite row from sprite memory, and writes the opaque pixels into the scanline buffer. The scanline buffer is external and double-buffered; scanout reads the other half.

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/sprite_row_shifter.sv | 39 +++
 rtl/draw_sprite_line.sv | 151 +++++++++++++++
 tb/tb_draw_sprite_line.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared OAM field layout, sprite geometry and draw FSM states
package sprite_pkg;

  localparam int ENABLE_BIT  = 31;
  localparam int YFLIP_BIT   = 30;
  localparam int XFLIP_BIT   = 29;
  localparam int PRIO_BIT    = 28;
  localparam int YPOS_MSB    = 27;
  localparam int YPOS_LSB    = 18;
  localparam int XPOS_MSB    = 17;
  localparam int XPOS_LSB    = 8;
  localparam int REF_MSB     = 7;
  localparam int REF_LSB     = 0;
  localparam int SPRITE_SIZE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_OAM_WAIT,
    ST_SPR_WAIT,
    ST_DRAW,
    ST_DONE
  } draw_state_t;

  // Only the low nibble of (line - ypos) matters, so the subtraction is done at 4 bits.
  function automatic logic [3:0] sprite_row(input logic [3:0] line_lo,
                                            input logic [3:0] ypos_lo,
                                            input logic       yflip);
    logic [3:0] diff;
    diff = line_lo - ypos_lo;
    return yflip ? ~diff : diff;
  endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// rtl/sprite_row_shifter.sv - 16-pixel row shift register with x-flip pixel order
module sprite_row_shifter
  import sprite_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_load,
  input  logic                       i_step,
  input  logic                       i_xflip,
  input  logic [4*SPRITE_SIZE-1:0]   i_row,
  output logic [3:0]                 o_pixel,
  output logic                       o_opaque,
  output logic [3:0]                 o_count,
  output logic                       o_last
);

  logic [4*SPRITE_SIZE-1:0] r_row;
  logic [3:0]               r_count;

  // A flipped row is consumed from the top nibble down, a normal row from the bottom up.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_row   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_row   <= i_row;
      r_count <= '0;
    end else if (i_step) begin
      r_row   <= i_xflip ? {r_row[4*SPRITE_SIZE-5:0], 4'h0} : {4'h0, r_row[4*SPRITE_SIZE-1:4]};
      r_count <= r_count + 4'd1;
    end
  end

  assign o_pixel  = i_xflip ? r_row[4*SPRITE_SIZE-1 -: 4] : r_row[3:0];
  assign o_opaque = |o_pixel;
  assign o_count  = r_count;
  assign o_last   = (r_count == 4'(SPRITE_SIZE - 1));

endmodule

// File: rtl/draw_sprite_line.sv
// rtl/draw_sprite_line.sv - walks the per-line sprite buffer and writes opaque pixels to the scanline buffer
module draw_sprite_line
  import sprite_pkg::*;
#(
  parameter int MAX_OBJECT_PER_LINE = 32,
  parameter int OAM_ADDR_SIZE       = 6,
  parameter int LINE_WIDTH          = 640
) (
  input  logic                                            i_clk,
  input  logic                                            i_reset,
  input  logic [MAX_OBJECT_PER_LINE-1:0][OAM_ADDR_SIZE:0] i_buffer_array,
  input  logic                                            i_line_prepared,
  input  logic [9:0]                                      i_sy,
  output logic [OAM_ADDR_SIZE-1:0]                        o_oam_addr,
  input  logic [31:0]                                     i_oam_data,
  output logic [11:0]                                     o_sprite_addr,
  input  logic [63:0]                                     i_sprite_data,
  output logic                                            o_linebuf_we,
  output logic [9:0]                                      o_linebuf_addr,
  output logic [4:0]                                      o_linebuf_data,
  output logic                                            o_line_done
);

  localparam int IDX_W = $clog2(MAX_OBJECT_PER_LINE);

  draw_state_t              r_state;
  logic [9:0]               r_drawn_sy;
  logic [IDX_W-1:0]         r_idx;
  logic [9:0]               r_xpos;
  logic                     r_xflip;
  logic                     r_prio;
  logic [OAM_ADDR_SIZE-1:0] r_oam_addr;
  logic [11:0]              r_sprite_addr;
  logic                     r_linebuf_we;
  logic [9:0]               r_linebuf_addr;
  logic [4:0]               r_linebuf_data;
  logic                     r_line_done;

  logic [OAM_ADDR_SIZE:0]   w_entry;
  logic                     w_sy_changed;
  logic                     w_walking;
  logic [3:0]               w_pixel;
  logic                     w_opaque;
  logic [3:0]               w_count;
  logic                     w_last;
  logic [10:0]              w_x;
  logic                     w_in_line;
  logic                     w_unused;

  assign w_entry      = i_buffer_array[r_idx];
  assign w_sy_changed = (i_sy != r_drawn_sy);
  assign w_walking    = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_x          = {1'b0, r_xpos} + {7'b0, w_count};
  assign w_in_line    = (w_x < 11'(LINE_WIDTH));
  assign w_unused     = ^{i_oam_data[ENABLE_BIT], i_oam_data[YPOS_MSB:YPOS_LSB+4]};

  sprite_row_shifter u_shifter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (r_state == ST_SPR_WAIT),
    .i_step   (r_state == ST_DRAW),
    .i_xflip  (r_xflip),
    .i_row    (i_sprite_data),
    .o_pixel  (w_pixel),
    .o_opaque (w_opaque),
    .o_count  (w_count),
    .o_last   (w_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_drawn_sy     <= 10'h3FF;
      r_idx          <= '0;
      r_xpos         <= '0;
      r_xflip        <= 1'b0;
      r_prio         <= 1'b0;
      r_oam_addr     <= '0;
      r_sprite_addr  <= '0;
      r_linebuf_we   <= 1'b0;
      r_linebuf_addr <= '0;
      r_linebuf_data <= '0;
      r_line_done    <= 1'b0;
    end else begin
      r_linebuf_we <= 1'b0;
      r_line_done  <= 1'b0;
      // A new line request mid-walk abandons the current one; earlier writes stay put.
      if (w_walking && w_sy_changed) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_line_prepared && w_sy_changed) begin
              r_drawn_sy <= i_sy;
              r_idx      <= IDX_W'(MAX_OBJECT_PER_LINE - 1);
              r_state    <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (w_entry[0]) begin
              r_oam_addr <= w_entry[OAM_ADDR_SIZE:1];
              r_state    <= ST_OAM_WAIT;
            end else if (r_idx == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_idx <= r_idx - IDX_W'(1);
            end
          end
          ST_OAM_WAIT: begin
            r_sprite_addr <= {i_oam_data[REF_MSB:REF_LSB],
                              sprite_row(r_drawn_sy[3:0], i_oam_data[YPOS_LSB+3:YPOS_LSB],
                                         i_oam_data[YFLIP_BIT])};
            r_xpos        <= i_oam_data[XPOS_MSB:XPOS_LSB];
            r_xflip       <= i_oam_data[XFLIP_BIT];
            r_prio        <= i_oam_data[PRIO_BIT];
            r_state       <= ST_SPR_WAIT;
          end
          ST_SPR_WAIT: begin
            r_state <= ST_DRAW;
          end
          ST_DRAW: begin
            r_linebuf_we   <= w_opaque && w_in_line;
            r_linebuf_addr <= w_x[9:0];
            r_linebuf_data <= {r_prio, w_pixel};
            if (w_last) begin
              if (r_idx == '0) begin
                r_state <= ST_DONE;
              end else begin
                r_idx   <= r_idx - IDX_W'(1);
                r_state <= ST_SCAN;
              end
            end
          end
          ST_DONE: begin
            if (w_sy_changed) r_state <= ST_IDLE;
            else              r_line_done <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_oam_addr     = r_oam_addr;
  assign o_sprite_addr  = r_sprite_addr;
  assign o_linebuf_we   = r_linebuf_we;
  assign o_linebuf_addr = r_linebuf_addr;
  assign o_linebuf_data = r_linebuf_data;
  assign o_line_done    = r_line_done;

endmodule

// File: tb/tb_draw_sprite_line.sv
// tb/tb_draw_sprite_line.sv - scoreboard bench for draw_sprite_line against a per-line reference model
module tb_draw_sprite_line;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0][6:0] buf_arr;
  logic             prep;
  logic [9:0]       sy;
  logic [5:0]       oam_addr;
  logic [31:0]      oam_data;
  logic [11:0]      sprite_addr;
  logic [63:0]      sprite_data;
  logic             lb_we;
  logic [9:0]       lb_addr;
  logic [4:0]       lb_data;
  logic             line_done;

  logic [31:0] oam_mem [64];
  logic [63:0] spr_mem [4096];
  int          shadow  [1024];

  typedef struct { int x; int d; } wr_t;
  wr_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int exp_n, exp_saddr, exp_oaddr;
  bit any_valid;
  int prev_sy;

  always #5 clk = ~clk;

  assign oam_data    = oam_mem[oam_addr];
  assign sprite_data = spr_mem[sprite_addr];

  draw_sprite_line dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_buffer_array  (buf_arr),
    .i_line_prepared (prep),
    .i_sy            (sy),
    .o_oam_addr      (oam_addr),
    .i_oam_data      (oam_data),
    .o_sprite_addr   (sprite_addr),
    .i_sprite_data   (sprite_data),
    .o_linebuf_we    (lb_we),
    .o_linebuf_addr  (lb_addr),
    .o_linebuf_data  (lb_data),
    .o_line_done     (line_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: highest entry first, each valid entry draws 16 pixels in screen order.
  task automatic model_line(input int line_sy, input int limit);
    int pushed = 0;
    exp_n = 1;
    any_valid = 0;
    for (int e = 31; e >= 0; e--) begin
      if (buf_arr[e][0]) begin
        int oi, w, ypos, xpos, row, ref_v, saddr;
        oi    = int'(buf_arr[e][6:1]);
        w     = int'(oam_mem[oi]);
        ypos  = (w >> 18) & 1023;
        xpos  = (w >> 8) & 1023;
        ref_v = w & 255;
        row   = (line_sy - ypos) & 15;
        if ((w >> 30) & 1) row = 15 - row;
        saddr = ref_v * 16 + row;
        for (int p = 0; p < 16; p++) begin
          int src, pix;
          src = ((w >> 29) & 1) ? 15 - p : p;
          pix = int'((spr_mem[saddr] >> (4 * src)) & 64'hF);
          if (pix != 0 && xpos + p < 640 && pushed < limit) begin
            q.push_back('{x: xpos + p, d: (((w >> 28) & 1) << 4) | pix});
            pushed++;
          end
        end
        exp_n += 19;
        any_valid = 1;
        exp_saddr = saddr;
        exp_oaddr = oi;
      end else begin
        exp_n += 1;
      end
    end
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 1024; i++) shadow[i] = -1;
  endtask

  task automatic run_line(input int line_sy);
    int cnt;
    sy   = 10'(line_sy);
    prep = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_low_before_start", int'(line_done), 0);
    clear_shadow();
    model_line(line_sy, 1 << 30);
    prep = 1'b1;
    @(negedge clk);
    cnt  = 1;
    prep = 1'b0;
    while (!line_done && cnt < 1500) begin
      @(negedge clk);
      cnt++;
    end
    chk("line_done_cycle", cnt, exp_n + 1);
    chk("scoreboard_empty", q.size(), 0);
    if (any_valid) begin
      chk("sprite_addr", int'(sprite_addr), exp_saddr);
      chk("oam_addr", int'(oam_addr), exp_oaddr);
    end
    prev_sy = line_sy;
  endtask

  task automatic clear_buf();
    for (int e = 0; e < 32; e++) buf_arr[e] = 7'h0;
  endtask

  function automatic logic [31:0] oam_word(input int yf, input int xf, input int pr,
                                           input int ypos, input int xpos, input int ref_v);
    return {1'b1, 1'(yf), 1'(xf), 1'(pr), 10'(ypos), 10'(xpos), 8'(ref_v)};
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < 64; i++) oam_mem[i] = $urandom;
    for (int i = 0; i < 4096; i++) begin
      logic [63:0] r;
      for (int p = 0; p < 16; p++)
        r[4*p +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      spr_mem[i] = r;
    end
  endtask

  task automatic randomize_buf();
    for (int e = 0; e < 32; e++)
      buf_arr[e] = ($urandom_range(0, 9) < 3) ? {6'($urandom_range(0, 63)), 1'b1} : 7'h0;
  endtask

  // Monitor: every write strobe pops and checks one expected pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && lb_we) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: x=%0d data=0x%0h, expected no write", lb_addr, lb_data);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("write_x", int'(lb_addr), e.x);
          chk("write_data", int'(lb_data), e.d);
        end
        shadow[lb_addr] = int'(lb_data);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int n, cyc, s;
    rst  = 1'b1;
    prep = 1'b0;
    sy   = 10'd0;
    clear_buf();
    randomize_mem();
    clear_shadow();
    repeat (2) @(negedge clk);
    chk("rst_oam_addr", int'(oam_addr), 0);
    chk("rst_sprite_addr", int'(sprite_addr), 0);
    chk("rst_we", int'(lb_we), 0);
    chk("rst_lb_addr", int'(lb_addr), 0);
    chk("rst_lb_data", int'(lb_data), 0);
    chk("rst_line_done", int'(line_done), 0);
    rst = 1'b0;
    @(negedge clk);

    // All entries invalid
    run_line(5);

    // Single sprite, no flips
    clear_buf();
    buf_arr[0] = {6'd3, 1'b1};
    oam_mem[3] = oam_word(0, 0, 0, 10, 100, 8'h12);
    spr_mem[12'h123] = 64'hF0E0_D0C0_B0A0_9080;
    run_line(13);
    chk("direct_sprite_addr", int'(sprite_addr), 12'h123);

    // Same sprite, both flips, row 3 becomes row 12
    oam_mem[3] = oam_word(1, 1, 0, 26, 100, 8'h12);
    spr_mem[12'h12C] = 64'hA000_1234_0567_89B0;
    run_line(29);
    chk("flip_sprite_addr", int'(sprite_addr), 12'h12C);
    chk("flip_pixel15_at_x100", shadow[100], 5'h0A);

    // Right-edge clipping
    oam_mem[3] = oam_word(0, 0, 1, 40, 630, 8'h50);
    spr_mem[12'h500] = 64'h1111_1111_1111_1111;
    run_line(40);
    chk("clip_x639", shadow[639], 5'h11);
    chk("clip_x640", shadow[640], -1);

    // Overlap: entry 5 drawn first, entry 0 wins at x=50
    clear_buf();
    buf_arr[0] = {6'd1, 1'b1};
    buf_arr[5] = {6'd2, 1'b1};
    oam_mem[1] = oam_word(0, 0, 0, 50, 50, 8'h30);
    oam_mem[2] = oam_word(0, 0, 1, 50, 45, 8'h31);
    spr_mem[12'h300] = 64'h2222_2222_2222_2222;
    spr_mem[12'h310] = 64'h7777_7777_7777_7777;
    run_line(50);
    chk("overlap_x50", shadow[50], 5'h02);
    chk("overlap_x47", shadow[47], 5'h17);

    // Abort seven pixels into DRAW
    clear_buf();
    buf_arr[0] = {6'd7, 1'b1};
    oam_mem[7] = oam_word(0, 0, 0, 16, 200, 8'h40);
    spr_mem[12'h404] = 64'h9876_5432_1FED_CBA9;
    sy   = 10'd20;
    prep = 1'b0;
    repeat (2) @(negedge clk);
    clear_shadow();
    model_line(20, 7);
    prep = 1'b1;
    @(negedge clk);
    prep = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 7 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (lb_we) n++;
    end
    chk("abort_writes_seen", n, 7);
    sy = 10'd21;
    @(negedge clk);
    chk("abort_we_drop", int'(lb_we), 0);
    repeat (3) @(negedge clk);
    chk("abort_line_done", int'(line_done), 0);
    chk("abort_scoreboard", q.size(), 0);
    run_line(21);

    // Randomized lines
    randomize_mem();
    for (int l = 0; l < 8; l++) begin
      randomize_buf();
      do s = $urandom_range(0, 524); while (s == prev_sy);
      run_line(s);
    end

    // Reset mid-line, then recovery
    randomize_buf();
    buf_arr[31] = {6'd9, 1'b1};
    do s = $urandom_range(0, 524); while (s == prev_sy);
    sy   = 10'(s);
    prep = 1'b0;
    repeat (2) @(negedge clk);
    model_line(s, 1 << 30);
    prep = 1'b1;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_we", int'(lb_we), 0);
    chk("midrst_line_done", int'(line_done), 0);
    chk("midrst_sprite_addr", int'(sprite_addr), 0);
    chk("midrst_oam_addr", int'(oam_addr), 0);
    q.delete();
    @(negedge clk);
    prep = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    run_line(s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
